// File: rtl/uart_rx_frame_cnt.sv
// Oversample edge / bit counter for the UART receiver: sample strobes, bit-done and frame-done pulses.
// Latency: all outputs registered, valid one cycle after the i_tick they respond to; no backpressure, i_en_cnt low clears next cycle.
// Optional sticky overrun flag when RX_CNT_OVERRUN_EN is defined.
module uart_rx_frame_cnt #(
    parameter int PRESCALE_W = 6,
    parameter int BIT_CNT_W  = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_en_cnt,
    input  logic                  i_tick,
    input  logic [PRESCALE_W-1:0] i_prescale,
    input  logic [BIT_CNT_W-1:0]  i_frame_bits,
    output logic [PRESCALE_W-1:0] o_edge_cnt,
    output logic [BIT_CNT_W-1:0]  o_bit_cnt,
    output logic                  o_sample_stb,
    output logic [1:0]            o_sample_idx,
    output logic                  o_bit_done,
    output logic                  o_frame_done,
    output logic                  o_busy
`ifdef RX_CNT_OVERRUN_EN
    ,
    output logic                  o_overrun
`endif
);

    typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;
    state_t state;

    localparam logic [PRESCALE_W-1:0] PRESC_MIN = PRESCALE_W'(4);
    localparam logic [BIT_CNT_W-1:0]  FB_MIN    = BIT_CNT_W'(2);

    // Limits captured at frame start; only the derived values the compares need are kept.
    logic [PRESCALE_W-1:0] presc_m1_q;
    logic [PRESCALE_W-1:0] mid_q;
    logic [BIT_CNT_W-1:0]  fb_q;
    logic [BIT_CNT_W-1:0]  fb_m1_q;

    logic [PRESCALE_W-1:0] presc_lat;
    logic [BIT_CNT_W-1:0]  fb_lat;
    logic [PRESCALE_W-1:0] edge_nxt;
    logic                  edge_wrap;
    logic                  last_bit;

    always_comb begin
        presc_lat = (i_prescale < PRESC_MIN) ? PRESC_MIN : i_prescale;
        fb_lat    = (i_frame_bits < FB_MIN) ? FB_MIN : i_frame_bits;
        edge_nxt  = o_edge_cnt + PRESCALE_W'(1);
        edge_wrap = (o_edge_cnt == presc_m1_q);
        last_bit  = (o_bit_cnt == fb_m1_q);
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state        <= IDLE;
            presc_m1_q   <= '0;
            mid_q        <= '0;
            fb_q         <= '0;
            fb_m1_q      <= '0;
            o_edge_cnt   <= '0;
            o_bit_cnt    <= '0;
            o_sample_stb <= 1'b0;
            o_sample_idx <= 2'd0;
            o_bit_done   <= 1'b0;
            o_frame_done <= 1'b0;
            o_busy       <= 1'b0;
`ifdef RX_CNT_OVERRUN_EN
            o_overrun    <= 1'b0;
`endif
        end else begin
            o_sample_stb <= 1'b0;
            o_bit_done   <= 1'b0;
            o_frame_done <= 1'b0;
            if (!i_en_cnt) begin
                state        <= IDLE;
                o_edge_cnt   <= '0;
                o_bit_cnt    <= '0;
                o_sample_idx <= 2'd0;
                o_busy       <= 1'b0;
`ifdef RX_CNT_OVERRUN_EN
                o_overrun    <= 1'b0;
`endif
            end else begin
                case (state)
                    IDLE: begin
                        presc_m1_q <= presc_lat - PRESCALE_W'(1);
                        mid_q      <= presc_lat >> 1;
                        fb_q       <= fb_lat;
                        fb_m1_q    <= fb_lat - BIT_CNT_W'(1);
                        o_busy     <= 1'b1;
                        state      <= COUNT;
                    end
                    COUNT: begin
                        if (i_tick) begin
                            if (edge_wrap) begin
                                o_edge_cnt <= '0;
                                o_bit_done <= 1'b1;
                                if (last_bit) begin
                                    o_bit_cnt    <= fb_q;
                                    o_frame_done <= 1'b1;
                                    o_busy       <= 1'b0;
                                    state        <= DONE;
                                end else begin
                                    o_bit_cnt <= o_bit_cnt + BIT_CNT_W'(1);
                                end
                            end else begin
                                o_edge_cnt <= edge_nxt;
                                // Wrap value 0 can never be a sample point since mid is at least 2.
                                if (edge_nxt == mid_q - PRESCALE_W'(1)) begin
                                    o_sample_stb <= 1'b1;
                                    o_sample_idx <= 2'd0;
                                end else if (edge_nxt == mid_q) begin
                                    o_sample_stb <= 1'b1;
                                    o_sample_idx <= 2'd1;
                                end else if (edge_nxt == mid_q + PRESCALE_W'(1)) begin
                                    o_sample_stb <= 1'b1;
                                    o_sample_idx <= 2'd2;
                                end
                            end
                        end
                    end
                    DONE: begin
`ifdef RX_CNT_OVERRUN_EN
                        if (i_tick) o_overrun <= 1'b1;
`endif
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_frame_cnt.sv
// Directed bench for uart_rx_frame_cnt: per-tick expected edge/bit/strobe values derived from the tick index.
module tb_uart_rx_frame_cnt;

    localparam int PW = 6;
    localparam int BW = 4;

    logic          i_clk = 1'b0;
    logic          i_rst = 1'b0;
    logic          i_en_cnt = 1'b0;
    logic          i_tick = 1'b0;
    logic [PW-1:0] i_prescale = '0;
    logic [BW-1:0] i_frame_bits = '0;
    logic [PW-1:0] o_edge_cnt;
    logic [BW-1:0] o_bit_cnt;
    logic          o_sample_stb;
    logic [1:0]    o_sample_idx;
    logic          o_bit_done;
    logic          o_frame_done;
    logic          o_busy;
`ifdef RX_CNT_OVERRUN_EN
    logic          o_overrun;
`endif

    uart_rx_frame_cnt #(.PRESCALE_W(PW), .BIT_CNT_W(BW)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_en_cnt     (i_en_cnt),
        .i_tick       (i_tick),
        .i_prescale   (i_prescale),
        .i_frame_bits (i_frame_bits),
        .o_edge_cnt   (o_edge_cnt),
        .o_bit_cnt    (o_bit_cnt),
        .o_sample_stb (o_sample_stb),
        .o_sample_idx (o_sample_idx),
        .o_bit_done   (o_bit_done),
        .o_frame_done (o_frame_done),
        .o_busy       (o_busy)
`ifdef RX_CNT_OVERRUN_EN
        ,
        .o_overrun    (o_overrun)
`endif
    );

    always #5 i_clk = ~i_clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic check_idle(input string nm);
        check($sformatf("%s/edge0", nm), 32'(o_edge_cnt), 0);
        check($sformatf("%s/bit0", nm), 32'(o_bit_cnt), 0);
        check($sformatf("%s/busy0", nm), 32'(o_busy), 0);
        check($sformatf("%s/stb0", nm), 32'(o_sample_stb), 0);
        check($sformatf("%s/bd0", nm), 32'(o_bit_done), 0);
        check($sformatf("%s/fd0", nm), 32'(o_frame_done), 0);
`ifdef RX_CNT_OVERRUN_EN
        check($sformatf("%s/ovr0", nm), 32'(o_overrun), 0);
`endif
    endtask

    // Runs one frame from IDLE. p/f are the effective (clamped) ratio and length.
    // gap = clocks per tick; abort_at/chg_at = tick index for abort / prescale change (0 = never).
    task automatic run_frame(input string nm, input int praw, input int fraw, input int p,
                             input int f, input int gap, input int abort_at, input int chg_at);
        int e, b, mid, total;
        logic exp_stb;
        total = p * f;
        mid   = p / 2;
        i_prescale   = PW'(praw);
        i_frame_bits = BW'(fraw);
        i_en_cnt     = 1'b1;
        i_tick       = 1'b1;   // a tick in the latch cycle must not count
        step();
        i_tick = 1'b0;
        check($sformatf("%s/latch_busy", nm), 32'(o_busy), 1);
        check($sformatf("%s/latch_edge", nm), 32'(o_edge_cnt), 0);
        check($sformatf("%s/latch_bit", nm), 32'(o_bit_cnt), 0);
        for (int k = 1; k <= total; k++) begin
            i_tick = 1'b1;
            step();
            i_tick = 1'b0;
            if (k == chg_at) i_prescale = PW'(16);
            e = k % p;
            b = k / p;
            exp_stb = (e == mid - 1) || (e == mid) || (e == mid + 1);
            check($sformatf("%s/k%0d/edge", nm, k), 32'(o_edge_cnt), 32'(e));
            check($sformatf("%s/k%0d/bit", nm, k), 32'(o_bit_cnt), 32'(b));
            check($sformatf("%s/k%0d/bd", nm, k), 32'(o_bit_done), 32'(e == 0));
            check($sformatf("%s/k%0d/fd", nm, k), 32'(o_frame_done), 32'(k == total));
            check($sformatf("%s/k%0d/busy", nm, k), 32'(o_busy), 32'(k != total));
            check($sformatf("%s/k%0d/stb", nm, k), 32'(o_sample_stb), 32'(exp_stb));
            if (exp_stb)
                check($sformatf("%s/k%0d/idx", nm, k), 32'(o_sample_idx), 32'(e - mid + 1));
            if (k == abort_at) begin
                i_en_cnt = 1'b0;
                step();
                check_idle($sformatf("%s/abort", nm));
                return;
            end
            for (int g = 1; g < gap; g++) begin
                step();
                check($sformatf("%s/k%0d/hold_edge", nm, k), 32'(o_edge_cnt), 32'(e));
                check($sformatf("%s/k%0d/hold_pulse", nm, k),
                      32'({o_sample_stb, o_bit_done, o_frame_done}), 0);
            end
        end
        // Stray tick while the FSM still holds enable in DONE.
        i_tick = 1'b1;
        step();
        i_tick = 1'b0;
        check($sformatf("%s/done_edge", nm), 32'(o_edge_cnt), 0);
        check($sformatf("%s/done_bit", nm), 32'(o_bit_cnt), 32'(f));
        check($sformatf("%s/done_busy", nm), 32'(o_busy), 0);
        check($sformatf("%s/done_pulse", nm), 32'({o_sample_stb, o_bit_done, o_frame_done}), 0);
`ifdef RX_CNT_OVERRUN_EN
        check($sformatf("%s/ovr_set", nm), 32'(o_overrun), 1);
        step();
        check($sformatf("%s/ovr_sticky", nm), 32'(o_overrun), 1);
`endif
        i_en_cnt = 1'b0;
        step();
        check_idle($sformatf("%s/release", nm));
    endtask

    initial begin
        step();
        step();
        check_idle("reset");
        i_rst = 1'b1;
        step();
        check_idle("post_reset");

        run_frame("t1_p8_f10_gap4", 8, 10, 8, 10, 4, 0, 0);
        run_frame("t2_p16_f11", 16, 11, 16, 11, 1, 0, 0);
        run_frame("t3_clamp", 2, 1, 4, 2, 1, 0, 0);
        run_frame("t4_abort", 8, 10, 8, 10, 1, 29, 0);
        run_frame("t4_restart", 8, 3, 8, 3, 1, 0, 0);
        run_frame("t5_chg", 8, 4, 8, 4, 2, 0, 5);
        run_frame("t_odd9", 9, 2, 9, 2, 1, 0, 0);

        // Asynchronous reset mid-frame clears outputs without waiting for a clock edge.
        i_prescale   = PW'(8);
        i_frame_bits = BW'(10);
        i_en_cnt     = 1'b1;
        step();
        for (int k = 1; k <= 11; k++) begin
            i_tick = 1'b1;
            step();
        end
        i_tick = 1'b0;
        check("arst/pre_stb", 32'(o_sample_stb), 1);
        check("arst/pre_bit", 32'(o_bit_cnt), 1);
        #2;
        i_rst = 1'b0;
        #1;
        check_idle("arst");
        check("arst/idx", 32'(o_sample_idx), 0);
        i_en_cnt = 1'b0;
        step();
        i_rst = 1'b1;
        step();
        run_frame("after_arst", 5, 2, 5, 2, 1, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
